// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the wb_gpio Wishbone GPIO controller: register map,
// word-index decode enum and interrupt type encodings.
package wb_gpio_pkg;

  localparam logic [4:0] REG_DATA_IN    = 5'h00;
  localparam logic [4:0] REG_DATA_OUT   = 5'h04;
  localparam logic [4:0] REG_DIR        = 5'h08;
  localparam logic [4:0] REG_IRQ_EN     = 5'h0C;
  localparam logic [4:0] REG_IRQ_TYPE   = 5'h10;
  localparam logic [4:0] REG_IRQ_POL    = 5'h14;
  localparam logic [4:0] REG_IRQ_STATUS = 5'h18;
  localparam logic [4:0] REG_RESERVED   = 5'h1C;

  typedef enum logic [2:0] {
    IDX_DATA_IN    = 3'(REG_DATA_IN >> 2),
    IDX_DATA_OUT   = 3'(REG_DATA_OUT >> 2),
    IDX_DIR        = 3'(REG_DIR >> 2),
    IDX_IRQ_EN     = 3'(REG_IRQ_EN >> 2),
    IDX_IRQ_TYPE   = 3'(REG_IRQ_TYPE >> 2),
    IDX_IRQ_POL    = 3'(REG_IRQ_POL >> 2),
    IDX_IRQ_STATUS = 3'(REG_IRQ_STATUS >> 2),
    IDX_RESERVED   = 3'(REG_RESERVED >> 2)
  } reg_idx_e;

  localparam logic IRQ_TYPE_EDGE  = 1'b1;
  localparam logic IRQ_TYPE_LEVEL = 1'b0;

endpackage

// File: rtl/gpio_in_cond.sv
// Pin input conditioning: 2-flop synchronizer, optional per-pin debounce
// (enabled by WB_GPIO_DEBOUNCE_EN), and a one-cycle delayed copy for edge detection.
module gpio_in_cond #(
  parameter int GPIO_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] i_gpio,
  output logic [GPIO_WIDTH-1:0] o_sync_in,
  output logic [GPIO_WIDTH-1:0] o_prev_in
);

  logic [GPIO_WIDTH-1:0] r_meta;
  logic [GPIO_WIDTH-1:0] r_raw;
  logic [GPIO_WIDTH-1:0] r_prev;
  logic [GPIO_WIDTH-1:0] w_sync;

  // Two-stage synchronizer for asynchronous pin inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_raw  <= '0;
    end else begin
      r_meta <= i_gpio;
      r_raw  <= r_meta;
    end
  end

`ifdef WB_GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]         r_cnt [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] r_filt;

  // Filtered value follows raw only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        if (r_raw[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i] <= r_raw[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_sync = r_filt;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign w_sync = r_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign o_sync_in = w_sync;
  assign o_prev_in = r_prev;

endmodule

// File: rtl/wb_gpio.sv
// Wishbone B4 pipelined GPIO slave: register file, per-pin edge/level interrupts,
// single-cycle response. Optional input debounce via WB_GPIO_DEBOUNCE_EN.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int WB_ADDRESS_WIDTH    = 32,
  parameter int WB_DATA_WIDTH       = 32,
  parameter int WB_DATA_GRANULARITY = 8,
  parameter int GPIO_WIDTH          = 32,
  parameter int DEBOUNCE_CYCLES     = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [WB_ADDRESS_WIDTH-1:0]                    i_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0]                       i_wb_dat,
  output logic [WB_DATA_WIDTH-1:0]                       o_wb_dat,
  input  logic                                           i_wb_cyc,
  input  logic                                           i_wb_stb,
  input  logic                                           i_wb_we,
  input  logic [WB_DATA_WIDTH/WB_DATA_GRANULARITY-1:0]   i_wb_sel,
  output logic                                           o_wb_ack,
  output logic                                           o_wb_stall,
  output logic                                           o_wb_err,
  input  logic [GPIO_WIDTH-1:0]                          i_gpio,
  output logic [GPIO_WIDTH-1:0]                          o_gpio,
  output logic [GPIO_WIDTH-1:0]                          o_gpio_oe,
  output logic                                           o_irq
);

  localparam int NSEL = WB_DATA_WIDTH / WB_DATA_GRANULARITY;

  // Replace selected byte lanes of old_v with new_v; bits beyond GPIO_WIDTH drop out
  function automatic logic [GPIO_WIDTH-1:0] lane_merge(
    input logic [GPIO_WIDTH-1:0]    old_v,
    input logic [WB_DATA_WIDTH-1:0] new_v,
    input logic [NSEL-1:0]          sel
  );
    logic [WB_DATA_WIDTH-1:0] m;
    logic [WB_DATA_WIDTH-1:0] o;
    m = '0;
    for (int b = 0; b < NSEL; b++) begin
      m[b*WB_DATA_GRANULARITY +: WB_DATA_GRANULARITY] = {WB_DATA_GRANULARITY{sel[b]}};
    end
    o = '0;
    o[GPIO_WIDTH-1:0] = old_v;
    o = (o & ~m) | (new_v & m);
    return o[GPIO_WIDTH-1:0];
  endfunction

  function automatic logic [WB_DATA_WIDTH-1:0] zext(input logic [GPIO_WIDTH-1:0] v);
    logic [WB_DATA_WIDTH-1:0] o;
    o = '0;
    o[GPIO_WIDTH-1:0] = v;
    return o;
  endfunction

  logic [GPIO_WIDTH-1:0]    r_data_out;
  logic [GPIO_WIDTH-1:0]    r_dir;
  logic [GPIO_WIDTH-1:0]    r_irq_en;
  logic [GPIO_WIDTH-1:0]    r_irq_type;
  logic [GPIO_WIDTH-1:0]    r_irq_pol;
  logic [GPIO_WIDTH-1:0]    r_irq_status;
  logic                     r_irq;
  logic                     r_ack;
  logic                     r_err;
  logic [WB_DATA_WIDTH-1:0] r_dat;

  logic [GPIO_WIDTH-1:0]    w_sync_in;
  logic [GPIO_WIDTH-1:0]    w_prev_in;
  logic [GPIO_WIDTH-1:0]    w_evt;
  logic [GPIO_WIDTH-1:0]    w_clr;
  logic [WB_DATA_WIDTH-1:0] w_rdat;
  logic                     w_req;
  logic                     w_bad;
  reg_idx_e                 w_idx;
  logic                     w_unused_addr;

  gpio_in_cond #(
    .GPIO_WIDTH      (GPIO_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_in_cond (
    .clk       (clk),
    .rst       (rst),
    .i_gpio    (i_gpio),
    .o_sync_in (w_sync_in),
    .o_prev_in (w_prev_in)
  );

  assign w_idx         = reg_idx_e'(i_wb_addr[4:2]);
  assign w_req         = i_wb_cyc & i_wb_stb;
  assign w_bad         = (w_idx == IDX_RESERVED) | (i_wb_we & (w_idx == IDX_DATA_IN));
  assign w_unused_addr = ^{i_wb_addr[WB_ADDRESS_WIDTH-1:5], i_wb_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_type <= '0;
      r_irq_pol  <= '0;
    end else if (w_req && i_wb_we) begin
      case (w_idx)
        IDX_DATA_OUT: r_data_out <= lane_merge(r_data_out, i_wb_dat, i_wb_sel);
        IDX_DIR:      r_dir      <= lane_merge(r_dir, i_wb_dat, i_wb_sel);
        IDX_IRQ_EN:   r_irq_en   <= lane_merge(r_irq_en, i_wb_dat, i_wb_sel);
        IDX_IRQ_TYPE: r_irq_type <= lane_merge(r_irq_type, i_wb_dat, i_wb_sel);
        IDX_IRQ_POL:  r_irq_pol  <= lane_merge(r_irq_pol, i_wb_dat, i_wb_sel);
        default:      ;
      endcase
    end
  end

  always_comb begin
    w_evt = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (r_irq_type[i] == IRQ_TYPE_EDGE) begin
        w_evt[i] = r_irq_pol[i] ? (w_sync_in[i] & ~w_prev_in[i])
                                : (~w_sync_in[i] & w_prev_in[i]);
      end else if (r_irq_type[i] == IRQ_TYPE_LEVEL) begin
        w_evt[i] = (w_sync_in[i] == r_irq_pol[i]);
      end else begin
        w_evt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_req && i_wb_we && (w_idx == IDX_IRQ_STATUS)) begin
      w_clr = lane_merge('0, i_wb_dat, i_wb_sel);
    end else begin
      w_clr = '0;
    end
  end

  // Set beats clear so a persisting level event re-arms the bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_clr) | w_evt;
      r_irq        <= |(r_irq_status & r_irq_en);
    end
  end

  always_comb begin
    w_rdat = '0;
    case (w_idx)
      IDX_DATA_IN:    w_rdat = zext(w_sync_in);
      IDX_DATA_OUT:   w_rdat = zext(r_data_out);
      IDX_DIR:        w_rdat = zext(r_dir);
      IDX_IRQ_EN:     w_rdat = zext(r_irq_en);
      IDX_IRQ_TYPE:   w_rdat = zext(r_irq_type);
      IDX_IRQ_POL:    w_rdat = zext(r_irq_pol);
      IDX_IRQ_STATUS: w_rdat = zext(r_irq_status);
      default:        w_rdat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else if (w_req) begin
      r_ack <= ~w_bad;
      r_err <= w_bad;
      r_dat <= (!i_wb_we && !w_bad) ? w_rdat : '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end
  end

  // A master that drops cyc before the response abandons it
  assign o_wb_ack   = r_ack & i_wb_cyc;
  assign o_wb_err   = r_err & i_wb_cyc;
  assign o_wb_dat   = r_dat;
  assign o_wb_stall = 1'b0;
  assign o_gpio     = r_data_out;
  assign o_gpio_oe  = r_dir;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_wb_gpio.sv
// Directed self-checking bench for wb_gpio (default build, 32 pins).
module tb_wb_gpio;

  logic        clk;
  logic        rst;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic        o_wb_err;
  logic [31:0] i_gpio;
  logic [31:0] o_gpio;
  logic [31:0] o_gpio_oe;
  logic        o_irq;

  int total = 0;
  int bad   = 0;

  wb_gpio dut (
    .clk        (clk),
    .rst        (rst),
    .i_wb_addr  (i_wb_addr),
    .i_wb_dat   (i_wb_dat),
    .o_wb_dat   (o_wb_dat),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_sel   (i_wb_sel),
    .o_wb_ack   (o_wb_ack),
    .o_wb_stall (o_wb_stall),
    .o_wb_err   (o_wb_err),
    .i_gpio     (i_gpio),
    .o_gpio     (o_gpio),
    .o_gpio_oe  (o_gpio_oe),
    .o_irq      (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  // One transfer; response sampled on the negedge of the cycle after accept
  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output logic ack, output logic err);
    @(negedge clk);
    i_wb_addr = addr; i_wb_we = we; i_wb_dat = wdat; i_wb_sel = sel;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = o_wb_ack; err = o_wb_err; rdat = o_wb_dat;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ack; logic err;
    logic [31:0] addrs [7];
    logic [31:0] exps  [7];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    // Level-low mode with all pins low raises every STATUS bit right after reset
    exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    total++;
    if ({o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall, o_gpio, o_gpio_oe, o_irq} !== 100'd0) begin
      bad++;
      $display("FAIL reset_outputs: got dat=%h ack=%b err=%b stall=%b gpio=%h oe=%h irq=%b, want all 0",
               o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall, o_gpio, o_gpio_oe, o_irq);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wb_xfer(addrs[i], 1'b0, 32'h0, 4'hF, rd, ack, err);
      total++;
      if (ack !== 1'b1 || err !== 1'b0 || rd !== exps[i]) begin
        bad++;
        $display("FAIL reset_read_%h: got ack=%b err=%b data=%h, want ack=1 err=0 data=%h",
                 addrs[i], ack, err, rd, exps[i]);
      end
    end
    total++;
    if (o_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b want 0", o_irq);
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'h08, 1'b1, 32'h0000_FFFF, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || o_gpio_oe !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL dir_write: got ack=%b err=%b oe=%h, want ack=1 err=0 oe=0000ffff", ack, err, o_gpio_oe);
    end
    wb_xfer(32'h04, 1'b1, 32'hA5A5_A5A5, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || o_gpio !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL dout_write: got ack=%b gpio=%h, want ack=1 gpio=a5a5a5a5", ack, o_gpio);
    end
    wb_xfer(32'h08, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || rd !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL dir_read: got ack=%b data=%h, want ack=1 data=0000ffff", ack, rd);
    end
    wb_xfer(32'h04, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || rd !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL dout_read: got ack=%b data=%h, want ack=1 data=a5a5a5a5", ack, rd);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'h04, 1'b1, 32'h1122_3344, 4'hF, rd, ack, err);
    wb_xfer(32'h04, 1'b1, 32'hFFFF_FFFF, 4'b0010, rd, ack, err);
    wb_xfer(32'h04, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h1122_FF44 || o_gpio !== 32'h1122_FF44) begin
      bad++;
      $display("FAIL byte_write: got read=%h gpio=%h, want 1122ff44", rd, o_gpio);
    end
  endtask

  task automatic test_irq_edge();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL status_cleared: got %h want 00000000", rd);
    end
    wb_xfer(32'h10, 1'b1, 32'h0000_0008, 4'hF, rd, ack, err);
    wb_xfer(32'h0C, 1'b1, 32'h0000_0008, 4'hF, rd, ack, err);
    i_gpio[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_irq !== 1'b0) begin
      bad++;
      $display("FAIL edge_irq_early: got irq=%b want 0 after 3 clk", o_irq);
    end
    @(posedge clk); #1;
    total++;
    if (o_irq !== 1'b1) begin
      bad++;
      $display("FAIL edge_irq_rise: got irq=%b want 1 after 4 clk", o_irq);
    end
    wb_xfer(32'h18, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0000_0008) begin
      bad++;
      $display("FAIL edge_status: got %h want 00000008", rd);
    end
    wb_xfer(32'h18, 1'b1, 32'h0000_0008, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0 || o_irq !== 1'b0) begin
      bad++;
      $display("FAIL edge_clear: got status=%h irq=%b want 00000000 and 0", rd, o_irq);
    end
  endtask

  task automatic test_irq_level();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'h14, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, ack, err);
    wb_xfer(32'h0C, 1'b1, 32'h0000_0009, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b1, 32'h0000_0001, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0000_0001 || o_irq !== 1'b1) begin
      bad++;
      $display("FAIL level_persist: got status=%h irq=%b want 00000001 and 1", rd, o_irq);
    end
    i_gpio[0] = 1'b1;
    repeat (3) @(posedge clk);
    wb_xfer(32'h18, 1'b1, 32'h0000_0001, 4'hF, rd, ack, err);
    wb_xfer(32'h18, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0 || o_irq !== 1'b0) begin
      bad++;
      $display("FAIL level_clear: got status=%h irq=%b want 00000000 and 0", rd, o_irq);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL datain_write_err: got ack=%b err=%b want ack=0 err=1", ack, err);
    end
    wb_xfer(32'h00, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || rd !== 32'h0000_0009) begin
      bad++;
      $display("FAIL datain_read: got ack=%b data=%h want ack=1 data=00000009", ack, rd);
    end
    wb_xfer(32'h1C, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b0 || err !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL rsvd_read: got ack=%b err=%b data=%h want ack=0 err=1 data=0", ack, err, rd);
    end
    wb_xfer(32'h1C, 1'b1, 32'h1234_5678, 4'hF, rd, ack, err);
    total++;
    if (ack !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL rsvd_write: got ack=%b err=%b want ack=0 err=1", ack, err);
    end
    wb_xfer(32'h04, 1'b1, 32'h0000_0000, 4'h0, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || o_gpio !== 32'h1122_FF44) begin
      bad++;
      $display("FAIL sel0_write: got ack=%b err=%b gpio=%h want ack=1 err=0 gpio=1122ff44", ack, err, o_gpio);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic ack; logic err;
    wb_xfer(32'hFFFF_FF28, 1'b1, 32'h0000_00F0, 4'hF, rd, ack, err);
    wb_xfer(32'h08, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h0000_00F0 || o_gpio_oe !== 32'h0000_00F0) begin
      bad++;
      $display("FAIL alias: got read=%h oe=%h want 000000f0", rd, o_gpio_oe);
    end
  endtask

  task automatic test_back_to_back();
    logic a1; logic a2; logic [31:0] d2;
    @(negedge clk);
    i_wb_addr = 32'h04; i_wb_we = 1'b1; i_wb_dat = 32'hCAFE_F00D; i_wb_sel = 4'hF;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a1 = o_wb_ack;
    i_wb_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a2 = o_wb_ack; d2 = o_wb_dat;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    total++;
    if (a1 !== 1'b1 || a2 !== 1'b1 || d2 !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL back_to_back: got ack1=%b ack2=%b data=%h want 1 1 cafef00d", a1, a2, d2);
    end
  endtask

  task automatic test_cyc_drop();
    logic [31:0] rd; logic ack; logic err;
    @(negedge clk);
    i_wb_addr = 32'h04; i_wb_we = 1'b1; i_wb_dat = 32'h5A5A_0000; i_wb_sel = 4'hF;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge clk);
    total++;
    if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0) begin
      bad++;
      $display("FAIL cyc_drop_resp: got ack=%b err=%b want 0 0", o_wb_ack, o_wb_err);
    end
    wb_xfer(32'h04, 1'b0, 32'h0, 4'hF, rd, ack, err);
    total++;
    if (rd !== 32'h5A5A_0000) begin
      bad++;
      $display("FAIL cyc_drop_write: got %h want 5a5a0000", rd);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_wb_addr = 32'h04; i_wb_we = 1'b0; i_wb_sel = 4'hF;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (o_wb_ack !== 1'b0 || o_wb_dat !== 32'h0 || o_gpio !== 32'h0 || o_gpio_oe !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: got ack=%b dat=%h gpio=%h oe=%h want all 0", o_wb_ack, o_wb_dat, o_gpio, o_gpio_oe);
    end
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_wb_addr = 32'h0; i_wb_dat = 32'h0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    i_wb_we = 1'b0; i_wb_sel = 4'h0; i_gpio = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic_rw();
    test_byte_write();
    test_irq_edge();
    test_irq_level();
    test_errors();
    test_alias();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
